// File: rtl/fft_pkg.sv
// fft_pkg: constants and types shared by the 16-point radix-4 FFT datapath.
//   DW      sample width; [33:17] real, [16:0] imaginary, two's complement
//   N       samples per frame (fixed at 16)
//   LANES   samples carried by one parallel beat
//   LANE_W  width of one lane inside a packed beat
package fft_pkg;

    localparam int DW     = 34;
    localparam int N      = 16;
    localparam int LANES  = 4;
    localparam int LANE_W = DW;

    // Address widths: sample index within a frame, and beat index within a frame.
    localparam int AW = $clog2(N);
    localparam int BW = $clog2(N / LANES);

    typedef struct packed {
        logic signed [16:0] re;
        logic signed [16:0] im;
    } cplx_t;

    // One parallel beat, lane j at [LANE_W*j +: LANE_W].
    typedef logic [LANES*LANE_W-1:0] beat_t;

endpackage

// File: rtl/s_p_buf_if.sv
// s_p_buf_if: serial-in / parallel-out stream bundle of the input buffer.
//   data_in, in_valid, in_ready       serial sample stream (one sample per beat)
//   data_out, out_valid, out_ready    parallel beat stream (LANES samples per beat)
//   frame_start                       marks beat 0 of each output frame
// master: the environment around the buffer; slave: the buffer itself.
interface s_p_buf_if;
    import fft_pkg::*;

    cplx_t data_in;
    logic  in_valid;
    logic  in_ready;
    beat_t data_out;
    logic  out_valid;
    logic  out_ready;
    logic  frame_start;

    modport master (
        output data_in, in_valid, out_ready,
        input  in_ready, data_out, out_valid, frame_start
    );

    modport slave (
        input  data_in, in_valid, out_ready,
        output in_ready, data_out, out_valid, frame_start
    );

endinterface

// File: rtl/s_p_bank.sv
// s_p_bank: one 16-sample frame store.
//   clk      clock, rising edge
//   we_i     write strobe
//   waddr_i  sample index to write (0..15)
//   wdata_i  sample to write
//   beat_i   beat index to read (0..3)
//   rdata_o  lane j = sample beat_i + 4*j (combinational read)
module s_p_bank
    import fft_pkg::*;
(
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  cplx_t         wdata_i,
    input  logic [BW-1:0] beat_i,
    output beat_t         rdata_o
);

    cplx_t mem_q [N];

    // NOTE: the storage has no reset; a bank is only read after a full frame
    // has been written into it, so stale contents are never observed.
    // NOTE: non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Sample index beat + 4*lane is simply {lane, beat}.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        localparam logic [AW-BW-1:0] LANE_SEL = (AW-BW)'(g);
        assign rdata_o[g*LANE_W +: LANE_W] = mem_q[{LANE_SEL, beat_i}];
    end

endmodule

// File: rtl/s_p_buf.sv
// s_p_buf: ping-pong serial-to-parallel input buffer for the 16-point FFT.
// Collects 16 serial samples into one bank while the other bank drains as
// four parallel beats, beat k carrying samples k, k+4, k+8, k+12.
//   clk   clock, rising edge
//   rst   asynchronous active-high reset
//   bus   s_p_buf_if.slave: data_in/in_valid/in_ready serial side,
//         data_out/out_valid/out_ready/frame_start parallel side
module s_p_buf
    import fft_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    s_p_buf_if.slave   bus
);

    logic [1:0]    full_q,    full_d;
    logic          wr_bank_q, wr_bank_d;
    logic [AW-1:0] wr_cnt_q,  wr_cnt_d;
    logic          rd_bank_q, rd_bank_d;
    logic [BW-1:0] rd_beat_q, rd_beat_d;

    logic  in_ready;
    logic  out_valid;
    logic  wr_fire;
    logic  rd_fire;
    beat_t rdata0;
    beat_t rdata1;

    // Handshake flags decode registered state only; no path from in_valid/out_ready.
    assign in_ready  = !full_q[wr_bank_q];
    assign out_valid = full_q[rd_bank_q];
    assign wr_fire   = bus.in_valid && in_ready;
    assign rd_fire   = out_valid && bus.out_ready;

    s_p_bank u_bank0 (
        .clk     (clk),
        .we_i    (wr_fire && !wr_bank_q),
        .waddr_i (wr_cnt_q),
        .wdata_i (bus.data_in),
        .beat_i  (rd_beat_q),
        .rdata_o (rdata0)
    );

    s_p_bank u_bank1 (
        .clk     (clk),
        .we_i    (wr_fire && wr_bank_q),
        .waddr_i (wr_cnt_q),
        .wdata_i (bus.data_in),
        .beat_i  (rd_beat_q),
        .rdata_o (rdata1)
    );

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.frame_start = out_valid && (rd_beat_q == '0);
    assign bus.data_out    = !out_valid ? '0 : (rd_bank_q ? rdata1 : rdata0);

    always_comb begin
        // NOTE: every next-state value gets its hold default first so no path
        // through this block leaves a variable unassigned (no latches).
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        wr_cnt_d  = wr_cnt_q;
        rd_bank_d = rd_bank_q;
        rd_beat_d = rd_beat_q;

        if (wr_fire) begin
            wr_cnt_d = wr_cnt_q + 1'b1;  // wraps 15 -> 0
            if (wr_cnt_q == AW'(N - 1)) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end
        end

        // A completing write targets an empty bank and a completing read a
        // full one, so these two updates never touch the same bit.
        if (rd_fire) begin
            rd_beat_d = rd_beat_q + 1'b1;  // wraps 3 -> 0
            if (rd_beat_q == BW'(N / LANES - 1)) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q    <= 2'b00;
            wr_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            rd_bank_q <= 1'b0;
            rd_beat_q <= '0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_bank_q <= rd_bank_d;
            rd_beat_q <= rd_beat_d;
        end
    end

endmodule

// File: tb/tb_s_p_buf.sv
// tb_s_p_buf: self-checking bench for s_p_buf. A frame-level reference model
// (queue of accepted samples, queue of expected beats) predicts every output
// each cycle; directed steps cover reset, throughput, stall, mid-frame reset
// and simultaneous bank completion, followed by a randomized run.
module tb_s_p_buf;
    import fft_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    s_p_buf_if bus ();

    s_p_buf dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks     = 0;
    int errors     = 0;
    int ir_low_cnt = 0;
    int beats_seen = 0;

    logic [DW-1:0] send_q    [$];  // samples waiting to be offered
    logic [DW-1:0] cur_frame [$];  // accepted samples of the frame being filled
    beat_t         exp_beats [$];  // beats of completed, undrained frames

    task automatic check(input string tag, input beat_t obs, input beat_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic beat_t pack4(input int a3, input int a2, input int a1, input int a0);
        return {DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
    endfunction

    // Frame-level model: once 16 samples are in, beat k = samples k,k+4,k+8,k+12.
    task automatic model_write(input logic [DW-1:0] s);
        cur_frame.push_back(s);
        if (cur_frame.size() == N) begin
            for (int k = 0; k < N / LANES; k++) begin
                beat_t b;
                b = '0;
                for (int j = 0; j < LANES; j++) begin
                    b[j*DW +: DW] = cur_frame[k + LANES*j];
                end
                exp_beats.push_back(b);
            end
            cur_frame.delete();
        end
    endtask

    task automatic model_clear();
        cur_frame.delete();
        exp_beats.delete();
        send_q.delete();
    endtask

    // One clock cycle: drive, check all outputs at the falling edge, then
    // account for the handshakes taken at the rising edge.
    task automatic step(input bit v, input bit r);
        logic          in_fire;
        logic          out_fire;
        logic [DW-1:0] d;
        bit            exp_ov;
        bit            exp_ir;
        bit            exp_fs;
        beat_t         exp_do;

        bus.in_valid  = v && (send_q.size() > 0);
        bus.data_in   = bus.in_valid ? send_q[0] : '0;
        bus.out_ready = r;

        @(negedge clk);
        exp_ov = exp_beats.size() > 0;
        exp_ir = ((exp_beats.size() + 3) / 4) < 2;
        exp_fs = exp_ov && (exp_beats.size() % 4 == 0);
        exp_do = exp_ov ? exp_beats[0] : '0;
        check("in_ready",    bus.in_ready,    exp_ir);
        check("out_valid",   bus.out_valid,   exp_ov);
        check("frame_start", bus.frame_start, exp_fs);
        check("data_out",    bus.data_out,    exp_do);
        if (!bus.in_ready) ir_low_cnt++;
        in_fire  = bus.in_valid && bus.in_ready;
        out_fire = bus.out_valid && bus.out_ready;
        d        = bus.data_in;

        @(posedge clk);
        if (out_fire && exp_beats.size() > 0) begin
            void'(exp_beats.pop_front());
            beats_seen++;
        end
        if (in_fire) begin
            model_write(d);
            void'(send_q.pop_front());
        end
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard;
        int base;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.data_in   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        check("rst_in_ready",    bus.in_ready,    1'b1);
        check("rst_out_valid",   bus.out_valid,   1'b0);
        check("rst_data_out",    bus.data_out,    '0);
        check("rst_frame_start", bus.frame_start, 1'b0);
        check("rst_full",        dut.full_q,      2'b00);

        // Single frame 0..15; beat 0 held until drained.
        for (int i = 0; i < 16; i++) send_q.push_back(DW'(i));
        repeat (16) step(1'b1, 1'b0);
        check("f0_valid",  bus.out_valid,   1'b1);
        check("f0_fs",     bus.frame_start, 1'b1);
        check("f0_beat0",  bus.data_out,    pack4(12, 8, 4, 0));
        repeat (4) step(1'b0, 1'b1);
        check("f0_drained", bus.out_valid,  1'b0);

        // Back-to-back frames 0..47 with out_ready high: no input stall.
        ir_low_cnt = 0;
        for (int i = 0; i < 48; i++) send_q.push_back(DW'(i));
        repeat (48) step(1'b1, 1'b1);
        check("b2b_no_stall", ir_low_cnt,    0);
        check("b2b_all_sent", send_q.size(), 0);
        repeat (4) step(1'b0, 1'b1);

        // Write-complete and read-complete on opposite banks in one edge.
        do_reset();
        for (int i = 0; i < 32; i++) send_q.push_back(DW'(i));
        repeat (28) step(1'b1, 1'b0);
        repeat (4)  step(1'b1, 1'b1);
        check("simul_full", dut.full_q, 2'b10);
        repeat (4) step(1'b0, 1'b1);

        // Output stalled while feeding 40 samples.
        for (int i = 0; i < 40; i++) send_q.push_back(DW'(i));
        repeat (45) step(1'b1, 1'b0);
        check("stall_in_ready", bus.in_ready,    1'b0);
        check("stall_held",     send_q.size(),   8);
        check("stall_beat0",    bus.data_out,    pack4(12, 8, 4, 0));
        check("stall_fs",       bus.frame_start, 1'b1);
        repeat (12) step(1'b1, 1'b1);
        check("stall_sent",     send_q.size(),   0);
        check("stall_drained",  bus.out_valid,   1'b0);
        check("stall_ready",    bus.in_ready,    1'b1);

        // Reset mid-frame while an output frame is mid-drain.
        do_reset();
        for (int i = 0; i < 23; i++) send_q.push_back(DW'(100 + i));
        repeat (23) step(1'b1, 1'b0);
        repeat (2)  step(1'b0, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", bus.out_valid,   1'b0);
        check("mid_rst_data_out",  bus.data_out,    '0);
        check("mid_rst_in_ready",  bus.in_ready,    1'b1);
        check("mid_rst_fs",        bus.frame_start, 1'b0);
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) send_q.push_back(DW'(200 + i));
        repeat (16) step(1'b1, 1'b0);
        check("clean_beat0", bus.data_out,    pack4(212, 208, 204, 200));
        check("clean_fs",    bus.frame_start, 1'b1);
        repeat (4) step(1'b0, 1'b1);

        // Random valid/ready over 100 frames of random samples.
        base = beats_seen;
        for (int i = 0; i < 100 * N; i++) begin
            logic [DW-1:0] s;
            s = {2'($urandom), 32'($urandom)};
            send_q.push_back(s);
        end
        guard = 0;
        while ((send_q.size() > 0 || exp_beats.size() > 0) && guard < 20000) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
            guard++;
        end
        check("rand_drained", send_q.size() + exp_beats.size(), 0);
        check("rand_beats",   beats_seen - base, 100 * (N / LANES));
        check("rand_partial", cur_frame.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/s_p_buf.md
# s_p_buf

Input serial-to-parallel buffer for the 16-point radix-4 FFT datapath, the mirror of the output parallel-to-serial stage.
- Accepts one 34-bit complex sample per beat and collects a 16-sample frame.
- Emits the frame as four 136-bit beats, beat k carrying samples k, k+4, k+8, k+12, as the first butterfly stage consumes them.
- Ping-pong (two-bank) buffered, so a new frame fills while the previous one drains; valid/ready on both sides.

## Interface
- DW, 34, sample width: [33:17] real, [16:0] imaginary, two's complement; passed through untouched
- N, 16, samples per frame (fixed; other values unsupported)
- LANES, 4, samples per output beat
- clk  in  1  single clock, rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- data_in  in  DW  input sample
- in_valid  in  1  data_in valid
- in_ready  out  1  block can accept data_in this cycle
- data_out  out  LANES*DW  lane j at [DW*j+DW-1 : DW*j]
- out_valid  out  1  data_out valid
- out_ready  in  1  downstream accepts data_out
- frame_start  out  1  high with beat 0 of each output frame (qualified by out_valid)

## Operation
- Storage: bank[2][16] of DW-bit registers, plus state per bank:
  - full[1:0]
  - write pointer: wr_bank (1b), wr_cnt (4b)
  - read pointer: rd_bank (1b), rd_beat (2b)
- Write on in_valid && in_ready:
  - store data_in at bank[wr_bank][wr_cnt], then wr_cnt++.
  - When wr_cnt==15: set full[wr_bank], toggle wr_bank, and wr_cnt wraps to 0.
- in_ready = !full[wr_bank] (combinational from state only, not from in_valid).
- out_valid = full[rd_bank].
- data_out lane j = bank[rd_bank][rd_beat + 4*j].
  - data_out is forced to 0 when !out_valid.
- frame_start = out_valid && rd_beat==0.
- Read on out_valid && out_ready: rd_beat++.
  - When rd_beat==3: clear full[rd_bank], toggle rd_bank, and rd_beat wraps to 0.
- Simultaneous events:
  - A frame completing on write and a frame finishing on read in the same cycle act on different banks; both updates apply.
  - A bank is never set and cleared in the same cycle.
- in_valid with in_ready low: the sample is not taken and the sender holds it. No overflow or drop path exists.
- out_valid, once high, stays high with data_out stable until accepted.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, data_out=0, frame_start=0.
  - All pointers 0; full=2'b00.
  - Bank contents are not reset.
- Reset mid-frame discards the partial input frame and any undrained output frame. Input restarts at sample 0 of bank 0.
- Latency: 16th sample accepted at edge t gives out_valid=1 from cycle t+1, with beat 0 presented.
- Throughput:
  - With out_ready held high, one frame drains in 4 cycles. in_ready never drops for a continuous 1-sample/cycle input.
  - Input stalls (in_ready=0) only when both banks are full.
- in_ready and out_valid are registered-state decodes with no combinational path from in_valid/out_ready.

## Structure
- Shared package fft_pkg:
  - DW, N, LANES.
  - Complex sample typedef: packed struct re[16:0], im[16:0].
  - Lane-pack helper constant LANE_W=DW.
- One natural sub-module: s_p_bank (16xDW register file, one write port, four-lane read at beat index). It is instantiated twice.
- Pointer/full control stays in the top.

## Test plan
- Reset release, then samples 0..15 (value = index) with in_valid continuous:
  - out_valid rises the cycle after sample 15.
  - Beats carry {12,8,4,0}, {13,9,5,1}, {14,10,6,2}, {15,11,7,3} (lane 3..0).
  - frame_start on the first beat only.
- Back-to-back frames 0..47 with out_ready=1: in_ready stays 1 throughout, and three correctly ordered output frames appear.
- out_ready=0 while feeding 40 samples:
  - in_ready drops after sample 31 is accepted.
  - Samples 32+ are held.
  - data_out holds {12,8,4,0} stable.
  - Releasing out_ready drains both frames in order and in_ready re-asserts.
- Random in_valid/out_ready toggling over 100 frames: a scoreboard matches every beat to the digit-reversed grouping and sees no loss or duplication.
- Assert rst after 7 samples of a frame and while an output frame is mid-drain:
  - out_valid=0, data_out=0, in_ready=1 immediately.
  - The next 16 samples form a clean frame.
- Simultaneous write-complete and read-complete on opposite banks (sample 31 accepted while beat 3 of frame 0 is accepted): full shows bank 1 set and bank 0 cleared in the same edge.
